// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC, requests the icache, and holds fetched words in a 2-entry skid buffer whose head is the IF/ID latch.
// One cycle from ihit to ifid_valid; fetch pauses while the buffer is full, and stall holds the head.
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h00000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iren,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        halted
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [1:0]  count_q;
  entry_t      head_q, tail_q, incoming;
  logic        accept, pop, halt_go, redir;

  assign iaddr      = pc_q;
  assign ifid_valid = (count_q != 2'd0);
  assign ifid_instr = head_q.instr;
  assign ifid_pc    = head_q.pc;
  assign ifid_npc   = head_q.npc;
  assign opcode     = ifid_valid ? head_q.instr[31:26] : 6'd0;
  assign funct      = ifid_valid ? head_q.instr[5:0]   : 6'd0;

  assign halt_go  = (state_q == RUN) && halt && ifid_valid && !stall;
  assign redir    = (state_q == RUN) && redirect_valid;
  assign accept   = iren && ihit;
  assign pop      = ifid_valid && !stall;
  assign incoming = '{pc: pc_q, npc: pc_q + 32'd4, instr: iload};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (halt_go) state_d = HALTED;
  end

  always_comb begin
    iren   = (state_q == RUN) && (count_q < 2'(BUF_DEPTH)) && !RST;
    halted = (state_q == HALTED);
  end

  // Halt beats redirect beats normal push/pop; emptying the buffer leaves head data in place.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= PC_INIT;
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (halt_go) begin
      count_q <= 2'd0;
    end else if (redir) begin
      pc_q    <= redirect_pc;
      count_q <= 2'd0;
    end else begin
      if (accept) pc_q <= pc_q + 32'd4;
      if (pop) begin
        if (count_q == 2'd2) head_q <= tail_q;
        else if (accept)     head_q <= incoming;
      end else if (accept) begin
        if (count_q == 2'd0) head_q <= incoming;
        else                 tail_q <= incoming;
      end
      count_q <= count_q + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: accepted words are queued by a reference model and compared at the IF/ID head.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect_valid, halt;
  logic [31:0] iload, redirect_pc;
  logic        iren, ifid_valid, halted;
  logic [31:0] iaddr, ifid_instr, ifid_pc, ifid_npc;
  logic [5:0]  opcode, funct;

  logic        w_rst, w_ihit;
  logic [31:0] w_iload;
  logic        w_iren, w_ifid_valid, w_halted;
  logic [31:0] w_iaddr, w_ifid_instr, w_ifid_pc, w_ifid_npc;
  logic [5:0]  w_opcode, w_funct;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h00000000), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc),
    .opcode(opcode), .funct(funct), .halted(halted)
  );

  fetch_stage #(.PC_INIT(32'hFFFFFFFC), .BUF_DEPTH(2)) dut_w (
    .CLK(CLK), .RST(w_rst), .iren(w_iren), .iaddr(w_iaddr), .ihit(w_ihit), .iload(w_iload),
    .stall(1'b1), .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .ifid_valid(w_ifid_valid), .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc), .ifid_npc(w_ifid_npc),
    .opcode(w_opcode), .funct(w_funct), .halted(w_halted)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] exp_pc;
  logic        exp_halted;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic step(input logic hit, input logic [31:0] ld, input logic stl,
                      input logic rv, input logic [31:0] rp, input logic hl);
    logic e_iren;
    ent_t h;
    ihit = hit; iload = ld; stall = stl; redirect_valid = rv; redirect_pc = rp; halt = hl;
    #1;
    e_iren = !exp_halted && (sb.size() < 2);
    chk("iren", {31'd0, iren}, {31'd0, e_iren});
    chk("iaddr", iaddr, exp_pc);
    chk("halted", {31'd0, halted}, {31'd0, exp_halted});
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      h = sb[0];
      chk("ifid_pc", ifid_pc, h.pc);
      chk("ifid_instr", ifid_instr, h.instr);
      chk("ifid_npc", ifid_npc, h.pc + 32'd4);
      chk("opcode", {26'd0, opcode}, {26'd0, h.instr[31:26]});
      chk("funct", {26'd0, funct}, {26'd0, h.instr[5:0]});
    end else begin
      chk("opcode_empty", {26'd0, opcode}, 32'd0);
      chk("funct_empty", {26'd0, funct}, 32'd0);
    end
    @(posedge CLK);
    if (!exp_halted) begin
      if (hl && sb.size() != 0 && !stl) begin
        exp_halted = 1'b1;
        sb.delete();
      end else if (rv) begin
        sb.delete();
        exp_pc = rp;
      end else begin
        if (sb.size() != 0 && !stl) void'(sb.pop_front());
        if (e_iren && hit) begin
          sb.push_back('{pc: exp_pc, instr: ld});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic stl);
    RST = 1'b1; stall = stl; ihit = 1'b1; iload = 32'hDEADBEEF;
    redirect_valid = 1'b0; halt = 1'b0;
    @(posedge CLK);
    sb.delete(); exp_pc = 32'h0; exp_halted = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_iren", {31'd0, iren}, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc", ifid_pc, 32'h0);
    chk("rst_npc", ifid_npc, 32'h0);
    RST = 1'b0;
    #1;
    chk("rst_release_iren", {31'd0, iren}, 32'd1);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; iload = '0; stall = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    w_rst = 1'b1; w_ihit = 1'b0; w_iload = '0;
    exp_pc = 32'h0; exp_halted = 1'b0;
    @(negedge CLK);

    // Back-to-back hits, no stall
    do_reset(1'b0);
    step(1, 32'h20010005, 0, 0, 0, 0);
    step(1, 32'h20020003, 0, 0, 0, 0);
    step(1, 32'h00221820, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);

    // Stall fills the buffer, release drains it and fetch resumes at 0x8
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1, 32'h11110000 + i, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h22220000 + i, 0, 0, 0, 0);

    // Redirect with a full buffer and a concurrent hit
    do_reset(1'b0);
    step(1, 32'h33330000, 1, 0, 0, 0);
    step(1, 32'h33330004, 1, 0, 0, 0);
    step(1, 32'h33330008, 1, 1, 32'h40, 0);
    step(1, 32'h8C010000, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);

    // Halt with a same-cycle redirect, then everything ignored
    do_reset(1'b0);
    step(1, 32'h44440000, 0, 0, 0, 0);
    step(1, 32'hFC000000, 0, 1, 32'h80, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h55550000, 0, i[0], 32'h100, 0);

    // Reset with a full buffer while stalled
    do_reset(1'b0);
    step(1, 32'h66660000, 1, 0, 0, 0);
    step(1, 32'h66660004, 1, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    do_reset(1'b1);
    step(1, 32'h77770000, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom & 32'hFFFFFFFC, 1'b0);
    end

    // PC wrap on the alternate instance
    @(posedge CLK);
    @(negedge CLK);
    w_rst = 1'b0; w_ihit = 1'b1; w_iload = 32'h24420001;
    #1;
    chk("wrap_iaddr0", w_iaddr, 32'hFFFFFFFC);
    @(posedge CLK);
    @(negedge CLK);
    w_iload = 32'h24420002;
    #1;
    chk("wrap_iaddr1", w_iaddr, 32'h00000000);
    chk("wrap_valid", {31'd0, w_ifid_valid}, 32'd1);
    chk("wrap_ifid_pc", w_ifid_pc, 32'hFFFFFFFC);
    chk("wrap_ifid_npc", w_ifid_npc, 32'h00000000);
    @(posedge CLK);
    @(negedge CLK);
    w_ihit = 1'b0;
    #1;
    chk("wrap_full_iren", {31'd0, w_iren}, 32'd0);
    chk("wrap_iaddr2", w_iaddr, 32'h00000004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode/control unit.
- Owns the PC and drives the icache request (iren/iaddr, ihit/iload).
- Holds fetched words in a 2-entry skid buffer whose head forms the IF/ID latch.
- Presents opcode/funct to the control unit, and handles decode stalls, branch/jump redirects and halt.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset.
BUF_DEPTH, 2, skid buffer entries; fixed at 2, any other value is unsupported.

Ports:
CLK  input  1  core clock, all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
iren  output  1  instruction read request to icache.
iaddr  output  32  fetch address (current PC).
ihit  input  1  icache hit; iload valid this cycle.
iload  input  32  instruction word from icache.
stall  input  1  decode cannot accept; hold IF/ID.
redirect_valid  input  1  branch/jump/jr resolved taken.
redirect_pc  input  32  new fetch target.
halt  input  1  control unit decoded HALT at IF/ID head.
ifid_valid  output  1  head entry valid.
ifid_instr  output  32  head instruction.
ifid_pc  output  32  PC of head instruction.
ifid_npc  output  32  ifid_pc + 4.
opcode  output  6  ifid_instr[31:26], zero when !ifid_valid.
funct  output  6  ifid_instr[5:0], zero when !ifid_valid.
halted  output  1  stage stopped.

Behaviour:
- Reset (RST high at edge):
  - pc=PC_INIT, count=0, state=RUN.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_npc=0, halted=0.
  - iren is 0 while RST is high.
- States:
  - RUN: normal fetch.
  - HALTED: iren=0, ifid_valid=0, halted=1.
  - The only exit from HALTED is RST.
- iren = (state==RUN) && (count<2) && !RST.
- iaddr = pc, combinational from the PC register.
- Accept: iren && ihit at edge → push {pc, iload}, pc <= pc+4 (mod 2^32, wraps).
- Latency: ihit in cycle n → ifid_valid=1 with that word in cycle n+1. No bubbles on back-to-back hits.
- Pop: at an edge with ifid_valid && !stall, the head retires and the next entry (if any) becomes the head.
- Simultaneous push+pop: count unchanged, FIFO order preserved.
- Full (count==2): iren=0, no push; the PC holds.
- Empty: ifid_valid=0, outputs hold the last value, opcode/funct=0 (reads as SLL nop).
- stall holds the head and ifid_* stable. Fetch continues until the buffer is full.
- Redirect (redirect_valid at edge):
  - pc <= redirect_pc, count <= 0, ifid_valid <= 0.
  - Any concurrent ihit word is discarded and the PC does not advance from it.
  - Redirect overrides stall and pop.
- Halt:
  - halt && ifid_valid && !stall at an edge → state <= HALTED, count <= 0.
  - Halt has priority over a same-cycle redirect and over ihit.
  - halt while stalled is ignored until the stall drops.
- RST mid-operation (e.g., buffer full, redirect pending) → full reset state next cycle. Nothing pending survives.
- ifid_npc is registered at push time as pc+4, not computed from the output.
- Outputs ifid_*, opcode, funct and halted come from flops/head storage with no combinational path from stall/redirect. iren depends only on state, count and RST, never on ihit.

Test Plan:
- Reset then ihit=1 every cycle with iload=32'h20010005, 32'h20020003, 32'h00221820 → iaddr 0,4,8 on consecutive cycles. ifid_instr follows one cycle later, ifid_npc=4,8,12, opcode=6'h08,6'h08,6'h00, funct=…,…,6'h20.
- stall=1 for 3 cycles with ihit=1 → buffer fills (count=2), iren drops after 2 pushes, iaddr holds at pc=0x8, ifid_pc stays 0x0. Releasing stall drains 0x0 then 0x4, and fetch resumes at 0x8.
- redirect_valid=1 with redirect_pc=0x40 while the buffer holds 2 entries and ihit=1 → next cycle ifid_valid=0 and iaddr=0x40. The first post-redirect ihit yields ifid_pc=0x40.
- halt=1 with ifid_valid=1, stall=0, plus redirect_valid=1 in the same cycle → halted=1, iren=0, ifid_valid=0 thereafter. Further ihit/redirect are ignored until RST.
- With PC_INIT=32'hFFFFFFFC, two hits → iaddr FFFFFFFC then 00000000 (wrap), ifid_npc of the first = 0.
- RST asserted with count=2 and stall=1 → next cycle ifid_valid=0, iaddr=PC_INIT, halted=0, and iren=1 once RST deasserts.
